// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants and helpers for the write-back stage:
//   REG_BUS    - datapath width (64)
//   ZERO_WORD  - all-zero datapath word
//   ld_funct3_e - load funct3 encodings (LB/LH/LW/LD/LBU/LHU/LWU)
//   ld_misaligned() - misalignment / illegal-encoding check for a load
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int REG_BUS = 64;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        LB    = 3'b000,
        LH    = 3'b001,
        LW    = 3'b010,
        LD    = 3'b011,
        LBU   = 3'b100,
        LHU   = 3'b101,
        LWU   = 3'b110,
        LNONE = 3'b111
    } ld_funct3_e;

    // funct3[1:0] encodes the access size, funct3[2] selects zero extension.
    // 3'b111 has no load defined and is reported as an exception.
    function automatic logic ld_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3 == LNONE) begin
            mis = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b00:   mis = 1'b0;
                2'b01:   mis = addr_lo[0];
                2'b10:   mis = (addr_lo[1:0] != 2'b00);
                default: mis = (addr_lo != 3'b000);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// wb_stage_load_align
// Combinational load data alignment: selects the addressed byte lane of the
// raw doubleword, then sign- or zero-extends it according to funct3.
// Ports:
//   funct3     in  3     load type
//   addr_lo    in  3     low address bits (byte offset in the doubleword)
//   rdata      in  XLEN  raw doubleword from data memory
//   data       out XLEN  aligned, extended load result (0 when misaligned)
//   misaligned out 1     misaligned access or undefined funct3
// ---------------------------------------------------------------------------
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = REG_BUS
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] lane;

    // Bring the addressed byte down to bit 0.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data       = ZERO_WORD[XLEN-1:0];
        misaligned = ld_misaligned(funct3, addr_lo);
        if (!misaligned) begin
            case (funct3)
                LB:      data = {{(XLEN-8){lane[7]}},   lane[7:0]};
                LH:      data = {{(XLEN-16){lane[15]}}, lane[15:0]};
                LW:      data = {{(XLEN-32){lane[31]}}, lane[31:0]};
                LD:      data = lane;
                LBU:     data = {{(XLEN-8){1'b0}},  lane[7:0]};
                LHU:     data = {{(XLEN-16){1'b0}}, lane[15:0]};
                LWU:     data = {{(XLEN-32){1'b0}}, lane[31:0]};
                default: data = ZERO_WORD[XLEN-1:0];
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage: merges ALU result with aligned load data, buffers up to
// DEPTH instructions in a skid FIFO and retires them to the register file /
// commit port under a valid/ready handshake. Also publishes forwarding info
// for the oldest and youngest buffered writers and a retire counter.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           upstream handshake (in_ready = not full)
//   m_data, m_w_ena, m_w_addr     ALU result and destination
//   wb_signal, reg_wr             MemtoReg select, register-write flag
//   ld_funct3, ld_addr_lo         load type and byte offset
//   mem_rdata                     raw doubleword from data memory
//   commit_valid / commit_ready   retire handshake
//   commit_exc                    head carries a misaligned-load exception
//   rf_w_ena, rf_w_addr, rf_w_data  register-file write port
//   fwd_y_*                       youngest buffered writer
//   fwd_o_*                       oldest buffered writer (head)
//   retire_cnt                    instructions retired since reset
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = REG_BUS,
    parameter int DEPTH = 2,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  m_data,
    input  logic             m_w_ena,
    input  logic [4:0]       m_w_addr,
    input  logic             wb_signal,
    input  logic             reg_wr,
    input  logic [2:0]       ld_funct3,
    input  logic [2:0]       ld_addr_lo,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic             commit_exc,
    output logic             rf_w_ena,
    output logic [4:0]       rf_w_addr,
    output logic [XLEN-1:0]  rf_w_data,
    output logic             fwd_y_valid,
    output logic [4:0]       fwd_y_addr,
    output logic [XLEN-1:0]  fwd_y_data,
    output logic             fwd_o_valid,
    output logic [4:0]       fwd_o_addr,
    output logic [XLEN-1:0]  fwd_o_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
    logic [XLEN-1:0] align_data;
    logic            align_mis;
    logic [XLEN-1:0] cap_data;
    logic            cap_exc;
    logic            cap_wen;

    wb_stage_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3     (ld_funct3),
        .addr_lo    (ld_addr_lo),
        .rdata      (mem_rdata),
        .data       (align_data),
        .misaligned (align_mis)
    );

    // Only loads can raise the exception; an excepting load never writes.
    assign cap_exc  = wb_signal & align_mis;
    assign cap_data = wb_signal ? align_data : m_data;
    assign cap_wen  = m_w_ena & reg_wr & (m_w_addr != 5'd0) & ~cap_exc;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0] count_reg,  count_next;
    logic [CNT_W-1:0] retire_cnt_reg, retire_cnt_next;
    logic             fire_in;
    logic             fire_out;

    assign in_ready     = (count_reg != OCC_W'(DEPTH));
    assign commit_valid = (count_reg != '0);
    assign fire_in      = in_valid & in_ready;
    assign fire_out     = commit_valid & commit_ready;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        retire_cnt_next = retire_cnt_reg;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (fire_in) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (fire_out) begin
            rd_ptr_next     = rd_ptr_reg + PTR_W'(1);
            retire_cnt_next = retire_cnt_reg + CNT_W'(1);
        end
        case ({fire_in, fire_out})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            retire_cnt_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            retire_cnt_reg <= retire_cnt_next;
        end
    end

    assign retire_cnt = retire_cnt_reg;

    // ------------------------------------------------------------------
    // Entry storage. Contents need no reset: every consumer is qualified
    // by count, so stale entries are never visible.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [4:0]      ent_addr [DEPTH];
    logic            ent_wen  [DEPTH];
    logic            ent_exc  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [XLEN-1:0] data_reg;
            logic [4:0]      addr_reg;
            logic            wen_reg;
            logic            exc_reg;

            always_ff @(posedge clk) begin
                if (fire_in && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= cap_data;
                    addr_reg <= m_w_addr;
                    wen_reg  <= cap_wen;
                    exc_reg  <= cap_exc;
                end
            end

            assign ent_data[gi] = data_reg;
            assign ent_addr[gi] = addr_reg;
            assign ent_wen[gi]  = wen_reg;
            assign ent_exc[gi]  = exc_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Retire and forwarding outputs
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] young_ptr;
    logic             head_wen;
    logic             young_wen;

    // Most recently written slot sits one behind the write pointer.
    assign young_ptr = wr_ptr_reg - PTR_W'(1);
    assign head_wen  = ent_wen[rd_ptr_reg];
    assign young_wen = ent_wen[young_ptr];

    assign commit_exc = commit_valid & ent_exc[rd_ptr_reg];

    assign rf_w_ena  = fire_out & head_wen;
    assign rf_w_addr = rf_w_ena ? ent_addr[rd_ptr_reg] : 5'd0;
    assign rf_w_data = rf_w_ena ? ent_data[rd_ptr_reg] : ZERO_WORD[XLEN-1:0];

    assign fwd_o_valid = commit_valid & head_wen;
    assign fwd_o_addr  = fwd_o_valid ? ent_addr[rd_ptr_reg] : 5'd0;
    assign fwd_o_data  = fwd_o_valid ? ent_data[rd_ptr_reg] : ZERO_WORD[XLEN-1:0];

    assign fwd_y_valid = commit_valid & young_wen;
    assign fwd_y_addr  = fwd_y_valid ? ent_addr[young_ptr] : 5'd0;
    assign fwd_y_data  = fwd_y_valid ? ent_data[young_ptr] : ZERO_WORD[XLEN-1:0];

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Table-driven bench for wb_stage with a scoreboard of expected commits.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] m_data;
    logic        m_w_ena;
    logic [4:0]  m_w_addr;
    logic        wb_signal;
    logic        reg_wr;
    logic [2:0]  ld_funct3;
    logic [2:0]  ld_addr_lo;
    logic [63:0] mem_rdata;
    logic        commit_valid;
    logic        commit_ready;
    logic        commit_exc;
    logic        rf_w_ena;
    logic [4:0]  rf_w_addr;
    logic [63:0] rf_w_data;
    logic        fwd_y_valid;
    logic [4:0]  fwd_y_addr;
    logic [63:0] fwd_y_data;
    logic        fwd_o_valid;
    logic [4:0]  fwd_o_addr;
    logic [63:0] fwd_o_data;
    logic [63:0] retire_cnt;

    wb_stage #(.XLEN(64), .DEPTH(2), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .m_data       (m_data),
        .m_w_ena      (m_w_ena),
        .m_w_addr     (m_w_addr),
        .wb_signal    (wb_signal),
        .reg_wr       (reg_wr),
        .ld_funct3    (ld_funct3),
        .ld_addr_lo   (ld_addr_lo),
        .mem_rdata    (mem_rdata),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_exc   (commit_exc),
        .rf_w_ena     (rf_w_ena),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .fwd_y_valid  (fwd_y_valid),
        .fwd_y_addr   (fwd_y_addr),
        .fwd_y_data   (fwd_y_data),
        .fwd_o_valid  (fwd_o_valid),
        .fwd_o_addr   (fwd_o_addr),
        .fwd_o_data   (fwd_o_data),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] m_data;
        logic        w_ena;
        logic [4:0]  w_addr;
        logic        wb_sig;
        logic        reg_wr;
        logic [2:0]  f3;
        logic [2:0]  lo;
        logic [63:0] rdata;
        logic        e_wen;
        logic [63:0] e_data;
        logic        e_exc;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        exc;
    } exp_t;

    localparam int NV = 17;
    vec_t tv [NV];
    exp_t sb [$];
    exp_t mon_e;

    int   n_vec      = 0;
    int   n_bad      = 0;
    logic [63:0] exp_retire = '0;
    logic stop_rand  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] md, input logic we, input logic [4:0] wa,
                                input logic ws, input logic rw, input logic [2:0] f3,
                                input logic [2:0] lo, input logic [63:0] rd,
                                input logic ew, input logic [63:0] ed, input logic ee);
        vec_t v;
        v.m_data = md; v.w_ena = we; v.w_addr = wa; v.wb_sig = ws; v.reg_wr = rw;
        v.f3 = f3; v.lo = lo; v.rdata = rd; v.e_wen = ew; v.e_data = ed; v.e_exc = ee;
        return v;
    endfunction

    // Commit monitor: one line per retired transaction.
    always @(negedge clk) begin
        if (!rst && commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_commit: got addr %0d with empty scoreboard", rf_w_addr);
            end else begin
                mon_e = sb.pop_front();
                $display("commit: ena=%0b addr=%0d data=0x%016h exc=%0b", rf_w_ena, rf_w_addr,
                         rf_w_data, commit_exc);
                chk("rf_w_ena", {63'd0, rf_w_ena}, {63'd0, mon_e.wen});
                chk("rf_w_addr", {59'd0, rf_w_addr}, {59'd0, mon_e.wen ? mon_e.addr : 5'd0});
                chk("rf_w_data", rf_w_data, mon_e.wen ? mon_e.data : 64'd0);
                chk("commit_exc", {63'd0, commit_exc}, {63'd0, mon_e.exc});
            end
            chk("retire_cnt", retire_cnt, exp_retire);
            exp_retire = exp_retire + 64'd1;
        end
    end

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        m_data     = v.m_data;
        m_w_ena    = v.w_ena;
        m_w_addr   = v.w_addr;
        wb_signal  = v.wb_sig;
        reg_wr     = v.reg_wr;
        ld_funct3  = v.f3;
        ld_addr_lo = v.lo;
        mem_rdata  = v.rdata;
    endtask

    // Offer one instruction; returns 1 ns after the edge that captured it.
    task automatic push(input vec_t v);
        int   t;
        exp_t e;
        drive(v);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            e.wen = v.e_wen; e.addr = v.w_addr; e.data = v.e_data; e.exc = v.e_exc;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d entries pending, required 0", sb.size());
        end
    endtask

    initial begin
        // {m_data, w_ena, w_addr, wb_sig, reg_wr, f3, lo, rdata, exp_wen, exp_data, exp_exc}
        tv[0]  = mk(64'h1234, 1, 5, 0, 1, 3'b000, 0, 64'h0, 1, 64'h1234, 0);
        tv[1]  = mk(64'h0, 1, 6, 1, 1, 3'b000, 3, 64'h8000_0000_FF00_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        tv[2]  = mk(64'h0, 1, 7, 1, 1, 3'b100, 3, 64'h8000_0000_FF00_0000, 1, 64'h0000_0000_0000_00FF, 0);
        tv[3]  = mk(64'h55, 1, 8, 1, 1, 3'b010, 2, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0, 1);
        tv[4]  = mk(64'h7, 1, 0, 0, 1, 3'b000, 0, 64'h0, 0, 64'h0, 0);
        tv[5]  = mk(64'h0, 1, 10, 1, 1, 3'b001, 0, 64'h0000_0000_0000_8001, 1, 64'hFFFF_FFFF_FFFF_8001, 0);
        tv[6]  = mk(64'h0, 1, 11, 1, 1, 3'b101, 6, 64'h1234_5678_9ABC_DEF0, 1, 64'h0000_0000_0000_1234, 0);
        tv[7]  = mk(64'h0, 1, 12, 1, 1, 3'b010, 4, 64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321, 0);
        tv[8]  = mk(64'h0, 1, 13, 1, 1, 3'b110, 4, 64'h8765_4321_0000_0000, 1, 64'h0000_0000_8765_4321, 0);
        tv[9]  = mk(64'h0, 1, 14, 1, 1, 3'b011, 0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 0);
        tv[10] = mk(64'h0, 1, 14, 1, 1, 3'b011, 4, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 1);
        tv[11] = mk(64'h0, 1, 15, 1, 1, 3'b111, 0, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 1);
        tv[12] = mk(64'h0, 1, 16, 1, 1, 3'b001, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 1);
        tv[13] = mk(64'hABCD, 1, 17, 0, 1, 3'b111, 5, 64'hFFFF, 1, 64'hABCD, 0);
        tv[14] = mk(64'h99, 1, 18, 0, 0, 3'b000, 0, 64'h0, 0, 64'h0, 0);
        tv[15] = mk(64'h98, 0, 19, 0, 1, 3'b000, 0, 64'h0, 0, 64'h0, 0);
        tv[16] = mk(64'h0, 1, 31, 1, 1, 3'b000, 0, 64'h0000_0000_0000_007F, 1, 64'h0000_0000_0000_007F, 0);

        rst = 1'b1; in_valid = 1'b0; commit_ready = 1'b0;
        m_data = '0; m_w_ena = 0; m_w_addr = 0; wb_signal = 0; reg_wr = 0;
        ld_funct3 = 0; ld_addr_lo = 0; mem_rdata = '0;
        #1;
        chk("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_retire_cnt", retire_cnt, 64'd0);
        chk("reset_fwd_valid", {62'd0, fwd_o_valid, fwd_y_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // count=1: both forwarding ports show the same entry
        push(mk(64'hD00D, 1, 9, 0, 1, 0, 0, 0, 1, 64'hD00D, 0));
        idle();
        chk("single_commit_valid", {63'd0, commit_valid}, 64'd1);
        chk("single_fwd_o_addr", {59'd0, fwd_o_addr}, 64'd9);
        chk("single_fwd_y_addr", {59'd0, fwd_y_addr}, 64'd9);
        chk("single_fwd_y_data", fwd_y_data, 64'hD00D);
        chk("single_fwd_valid", {62'd0, fwd_o_valid, fwd_y_valid}, 64'd3);
        commit_ready = 1'b1;
        drain();

        // x0 destination: no forwarding, no register write
        commit_ready = 1'b0;
        push(tv[4]);
        idle();
        chk("x0_fwd_valid", {62'd0, fwd_o_valid, fwd_y_valid}, 64'd0);
        commit_ready = 1'b1;
        drain();

        // Table pass, commit_ready held high: back-to-back throughput
        for (int i = 0; i < NV; i++) push(tv[i]);
        idle();
        drain();

        // Table pass with commit_ready toggling
        fork
            begin
                for (int i = NV - 1; i >= 0; i--) push(tv[i]);
                idle();
                stop_rand = 1'b1;
                #20;
                commit_ready = 1'b1;
                drain();
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #2;
                    if (!stop_rand) commit_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        // Backpressure: fill, third offer held, head stable
        commit_ready = 1'b0;
        push(mk(64'hA1, 1, 20, 0, 1, 0, 0, 0, 1, 64'hA1, 0));
        push(mk(64'hB2, 1, 21, 0, 1, 0, 0, 0, 1, 64'hB2, 0));
        drive(mk(64'hC3, 1, 22, 0, 1, 0, 0, 0, 1, 64'hC3, 0));
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_fwd_o_addr", {59'd0, fwd_o_addr}, 64'd20);
        chk("full_fwd_o_data", fwd_o_data, 64'hA1);
        chk("full_fwd_y_addr", {59'd0, fwd_y_addr}, 64'd21);
        chk("full_fwd_y_data", fwd_y_data, 64'hB2);
        @(posedge clk);
        #1;
        chk("hold_fwd_o_addr", {59'd0, fwd_o_addr}, 64'd20);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        commit_ready = 1'b1;
        push(mk(64'hC3, 1, 22, 0, 1, 0, 0, 0, 1, 64'hC3, 0));
        idle();
        drain();
        chk("retire_total", retire_cnt, exp_retire);

        // Asynchronous reset with two entries buffered
        commit_ready = 1'b0;
        push(mk(64'hE1, 1, 23, 0, 1, 0, 0, 0, 1, 64'hE1, 0));
        push(mk(64'hE2, 1, 24, 0, 1, 0, 0, 0, 1, 64'hE2, 0));
        chk("pre_reset_full", {63'd0, in_ready}, 64'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("async_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_retire_cnt", retire_cnt, 64'd0);
        chk("async_fwd_valid", {62'd0, fwd_o_valid, fwd_y_valid}, 64'd0);
        sb.delete();
        exp_retire = '0;
        @(posedge clk);
        #1;
        chk("reset_no_capture", {63'd0, commit_valid}, 64'd0);
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_empty", {63'd0, commit_valid}, 64'd0);

        // Normal operation after reset; retire counter restarts at 0
        commit_ready = 1'b1;
        push(tv[0]);
        push(tv[1]);
        idle();
        drain();
        chk("post_reset_retire", retire_cnt, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
